ramen_timer_ctrl: RTL



---
 rtl/ramen_timer_ctrl.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ramen_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ramen_timer_ctrl
// Purpose  : Top-level sequencer for the ramen timer. Holds an MM:SS BCD
//            countdown, runs the IDLE/RUN/PAUSE/ALARM state machine from
//            debounced button pulses, derives the 1 s tick, multiplexes the
//            four digits onto one 7-segment bus and drives the buzzer.
// Ports    : clk        - system clock
//            rst_n      - synchronous reset, active-low
//            btn_start  - pulse: start / pause / resume / acknowledge
//            btn_min    - pulse: add one minute (IDLE only)
//            btn_clear  - pulse: zero the time, return to IDLE
//            seg_out    - segments {a,b,c,d,e,f,g,dp}, active-high
//            dig_sel    - one-hot digit enable (bit0 = seconds units)
//            buzzer     - high throughout ALARM
//            done       - one-cycle pulse on entry to ALARM
//            state_o    - IDLE=0, RUN=1, PAUSE=2, ALARM=3
// Options  : RAMEN_TIMER_BLINK_EN - blank the display for the second half of
//            every tick period while in PAUSE or ALARM.
// Revision : 1.0 - initial release
// ============================================================================
module ramen_timer_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int SCAN_DIV    = 50000,
  parameter int DEFAULT_MIN = 3,
  parameter int BEEP_SEC    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_clear,
  output logic [7:0] seg_out,
  output logic [3:0] dig_sel,
  output logic       buzzer,
  output logic       done,
  output logic [1:0] state_o
);

  localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_BEEP_W-1:0] c_BEEP_LAST = c_BEEP_W'(BEEP_SEC - 1);

  // Reset time DEFAULT_MIN:00 as {min tens, min units, sec tens, sec units}
  localparam logic [15:0] c_DEFAULT_TIME = {4'(DEFAULT_MIN / 10),
                                            4'(DEFAULT_MIN % 10), 8'h00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t              r_state, w_state_n;
  logic [15:0]         r_time, w_time_n;
  logic [15:0]         r_preset, w_preset_n;
  logic [c_TICK_W-1:0] r_presc, w_presc_n;
  logic [c_BEEP_W-1:0] r_beep, w_beep_n;
  logic                r_done, w_done_n;
  logic [c_SCAN_W-1:0] r_scan_cnt;
  logic [1:0]          r_scan_idx;

  logic                w_tick;
  logic [15:0]         w_time_dec;
  logic [3:0]          w_digit;
  logic [7:0]          w_seg;
  logic                w_blank;

  // One-second decrement of a non-zero BCD MM:SS value
  function automatic logic [15:0] f_bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Add one minute, 99 wraps to 00, seconds untouched
  function automatic logic [15:0] f_min_inc(input logic [15:0] t);
    logic [3:0] mt, mu;
    {mt, mu} = t[15:8];
    if (mu == 4'd9) begin
      mu = 4'd0;
      mt = (mt == 4'd9) ? 4'd0 : mt + 4'd1;
    end else begin
      mu = mu + 4'd1;
    end
    return {mt, mu, t[7:0]};
  endfunction

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b1111_1100;
      4'd1:    s = 8'b0110_0000;
      4'd2:    s = 8'b1101_1010;
      4'd3:    s = 8'b1111_0010;
      4'd4:    s = 8'b0110_0110;
      4'd5:    s = 8'b1011_0110;
      4'd6:    s = 8'b1011_1110;
      4'd7:    s = 8'b1110_0000;
      4'd8:    s = 8'b1111_1110;
      4'd9:    s = 8'b1111_0110;
      default: s = 8'b0000_0010;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_presc == c_TICK_LAST);
  assign w_time_dec = f_bcd_dec(r_time);

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n  = r_state;
    w_time_n   = r_time;
    w_preset_n = r_preset;
    w_presc_n  = r_presc;
    w_beep_n   = r_beep;
    w_done_n   = 1'b0;

    // The prescaler only advances while time is flowing; the edge that
    // pauses still counts, so a resume continues the same second.
    if (r_state == S_RUN || r_state == S_ALARM) begin
      w_presc_n = w_tick ? '0 : r_presc + c_TICK_W'(1);
    end

    if (btn_clear) begin
      w_state_n = S_IDLE;
      w_time_n  = 16'h0000;
      w_presc_n = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (btn_start) begin
            if (r_time != 16'h0000) begin
              w_preset_n = r_time;
              w_presc_n  = '0;
              w_state_n  = S_RUN;
            end
          end else if (btn_min) begin
            w_time_n = f_min_inc(r_time);
          end
        end
        S_RUN: begin
          if (w_tick && w_time_dec == 16'h0000) begin
            // Reaching zero wins over a simultaneous pause request
            w_time_n  = w_time_dec;
            w_state_n = S_ALARM;
            w_done_n  = 1'b1;
            w_presc_n = '0;
            w_beep_n  = '0;
          end else begin
            if (w_tick) begin
              w_time_n = w_time_dec;
            end
            if (btn_start) begin
              w_state_n = S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (btn_start) begin
            w_state_n = S_RUN;
          end
        end
        S_ALARM: begin
          if (btn_start || (w_tick && r_beep == c_BEEP_LAST)) begin
            w_state_n = S_IDLE;
            w_time_n  = r_preset;
            w_presc_n = '0;
            w_beep_n  = '0;
          end else if (w_tick) begin
            w_beep_n = r_beep + c_BEEP_W'(1);
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_time   <= c_DEFAULT_TIME;
      r_preset <= c_DEFAULT_TIME;
      r_presc  <= '0;
      r_beep   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_time   <= w_time_n;
      r_preset <= w_preset_n;
      r_presc  <= w_presc_n;
      r_beep   <= w_beep_n;
      r_done   <= w_done_n;
    end
  end

  // --------------------------------------------------------------------------
  // Display multiplexing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 2'd0;
    end else if (r_scan_cnt == c_SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
    end
  end

  always_comb begin
    w_digit = 4'd0;
    case (r_scan_idx)
      2'd0: w_digit = r_time[3:0];
      2'd1: w_digit = r_time[7:4];
      2'd2: w_digit = r_time[11:8];
      2'd3: w_digit = r_time[15:12];
      default: w_digit = 4'd0;
    endcase
    w_seg = f_seg(w_digit);
    // dp on the minutes-units digit forms the MM:SS colon
    if (r_scan_idx == 2'd2) begin
      w_seg[0] = 1'b1;
    end
  end

`ifdef RAMEN_TIMER_BLINK_EN
  logic [c_TICK_W-1:0] r_blink;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink <= '0;
    end else if (r_blink == c_TICK_LAST) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + c_TICK_W'(1);
    end
  end

  assign w_blank = (r_state == S_PAUSE || r_state == S_ALARM) &&
                   (r_blink >= c_TICK_W'(TICK_DIV / 2));
`else
  assign w_blank = 1'b0;
`endif

  assign seg_out = w_blank ? 8'h00 : w_seg;
  assign dig_sel = 4'b0001 << r_scan_idx;
  assign buzzer  = (r_state == S_ALARM);
  assign done    = r_done;
  assign state_o = r_state;

endmodule
`default_nettype wire
